ysyx_040978_lut_writer: RTL and testbench

Programmable key/data table that builds and maintains the packed lookup bus consumed by the team's key-select mux (`NR_KEY` pairs, key in the upper bits of each pair, data in the lower bits). It is the write side of that lookup interface. A command port inserts or updates, deletes, and clears entries through a sequential scan. The table drives `lut` plus a per-entry valid mask straight into the mux.

---
 rtl/ysyx_040978_lut_pkg.sv | 21 ++
 rtl/ysyx_040978_lut_slot.sv | 54 +++++
 rtl/ysyx_040978_lut_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_ysyx_040978_lut_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040978_lut_pkg.sv
// Shared encodings for the key/data lookup-table writer: command ops, response
// status codes and controller state.
package ysyx_040978_lut_pkg;

    localparam logic [1:0] OpWrite  = 2'b00;
    localparam logic [1:0] OpDelete = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;
    localparam logic [1:0] OpRsvd   = 2'b11;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatUpdated = 2'b01;
    localparam logic [1:0] StatMiss    = 2'b10;
    localparam logic [1:0] StatFull    = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StCommit = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_040978_lut_slot.sv
// One table slot: valid/key/data storage with load and clear controls.
// Key and data read as zero while the slot is invalid.
module ysyx_040978_lut_slot #(
    parameter int unsigned KEY_LEN  = 4,
    parameter int unsigned DATA_LEN = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic                clear_i,
    input  logic [KEY_LEN-1:0]  key_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic                valid_o,
    output logic [KEY_LEN-1:0]  key_o,
    output logic [DATA_LEN-1:0] data_o
);

    logic                valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q, key_d;
    logic [DATA_LEN-1:0] data_q, data_d;

    // Clear wins over load so a stale slot can never survive a CLEAR.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            key_d   = '0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            key_d   = key_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign key_o   = valid_q ? key_q : '0;
    assign data_o  = valid_q ? data_q : '0;

endmodule

// File: rtl/ysyx_040978_lut_writer.sv
// Write side of the key-select lookup table: sequential scan for hit/free slot,
// then a single commit cycle that inserts, updates, deletes or clears entries.
module ysyx_040978_lut_writer
    import ysyx_040978_lut_pkg::*;
#(
    parameter int unsigned NR_KEY   = 4,
    parameter int unsigned KEY_LEN  = 4,
    parameter int unsigned DATA_LEN = 8
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic [1:0]                             req_op_i,
    input  logic [KEY_LEN-1:0]                     req_key_i,
    input  logic [DATA_LEN-1:0]                    req_data_i,
    output logic                                   resp_valid_o,
    output logic [1:0]                             resp_status_o,
    output logic [$clog2(NR_KEY)-1:0]              resp_index_o,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut_o,
    output logic [NR_KEY-1:0]                      entry_valid_o,
    output logic [$clog2(NR_KEY+1)-1:0]            count_o,
    output logic                                   full_o,
    output logic                                   empty_o
);

    localparam int unsigned PAIR  = KEY_LEN + DATA_LEN;
    localparam int unsigned IDX_W = $clog2(NR_KEY);
    localparam int unsigned CNT_W = $clog2(NR_KEY + 1);

    state_e state_q, state_d;

    logic [1:0]          op_q, op_d;
    logic [KEY_LEN-1:0]  key_q, key_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [IDX_W-1:0]    scan_q, scan_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
    logic                free_q, free_d;
    logic [IDX_W-1:0]    free_idx_q, free_idx_d;

    logic                resp_valid_q, resp_valid_d;
    logic [1:0]          resp_status_q, resp_status_d;
    logic [IDX_W-1:0]    resp_index_q, resp_index_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                accept;
    logic                scan_last;
    logic                scan_match;
    logic                scan_free;
    logic [NR_KEY-1:0]   load_vec;
    logic [NR_KEY-1:0]   clear_vec;

    logic [NR_KEY-1:0]   slot_valid;
    logic [KEY_LEN-1:0]  slot_key  [NR_KEY];
    logic [DATA_LEN-1:0] slot_data [NR_KEY];

    assign accept     = req_valid_i && (state_q == StIdle);
    assign scan_last  = (scan_q == IDX_W'(NR_KEY - 1));
    assign scan_match = slot_valid[scan_q] && (slot_key[scan_q] == key_q);
    assign scan_free  = !slot_valid[scan_q];

    // State register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = (req_op_i == OpWrite || req_op_i == OpDelete) ? StSearch : StCommit;
                end
            end
            StSearch: begin
                if (scan_last) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Command latch and scan trackers; only the first hit and lowest free slot stick.
    always_comb begin
        op_d       = op_q;
        key_d      = key_q;
        data_d     = data_q;
        scan_d     = scan_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        free_d     = free_q;
        free_idx_d = free_idx_q;
        if (accept) begin
            op_d       = req_op_i;
            key_d      = req_key_i;
            data_d     = req_data_i;
            scan_d     = '0;
            hit_d      = 1'b0;
            hit_idx_d  = '0;
            free_d     = 1'b0;
            free_idx_d = '0;
        end else if (state_q == StSearch) begin
            if (!hit_q && scan_match) begin
                hit_d     = 1'b1;
                hit_idx_d = scan_q;
            end
            if (!free_q && scan_free) begin
                free_d     = 1'b1;
                free_idx_d = scan_q;
            end
            if (!scan_last) begin
                scan_d = scan_q + IDX_W'(1);
            end
        end
    end

    // Output logic: ready, slot controls and registered response/count.
    always_comb begin
        req_ready_o   = (state_q == StIdle);
        load_vec      = '0;
        clear_vec     = '0;
        resp_valid_d  = 1'b0;
        resp_status_d = resp_status_q;
        resp_index_d  = resp_index_q;
        count_d       = count_q;
        if (state_q == StCommit) begin
            resp_valid_d = 1'b1;
            resp_index_d = '0;
            case (op_q)
                OpWrite: begin
                    if (hit_q) begin
                        load_vec[hit_idx_q] = 1'b1;
                        resp_status_d       = StatUpdated;
                        resp_index_d        = hit_idx_q;
                    end else if (free_q) begin
                        load_vec[free_idx_q] = 1'b1;
                        resp_status_d        = StatOk;
                        resp_index_d         = free_idx_q;
                        count_d              = count_q + CNT_W'(1);
                    end else begin
                        resp_status_d = StatFull;
                    end
                end
                OpDelete: begin
                    if (hit_q) begin
                        clear_vec[hit_idx_q] = 1'b1;
                        resp_status_d        = StatOk;
                        resp_index_d         = hit_idx_q;
                        count_d              = count_q - CNT_W'(1);
                    end else begin
                        resp_status_d = StatMiss;
                    end
                end
                OpClear: begin
                    clear_vec     = '1;
                    resp_status_d = StatOk;
                    count_d       = '0;
                end
                default: resp_status_d = StatMiss;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            op_q          <= OpWrite;
            key_q         <= '0;
            data_q        <= '0;
            scan_q        <= '0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            free_q        <= 1'b0;
            free_idx_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= StatOk;
            resp_index_q  <= '0;
            count_q       <= '0;
        end else begin
            op_q          <= op_d;
            key_q         <= key_d;
            data_q        <= data_d;
            scan_q        <= scan_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            free_q        <= free_d;
            free_idx_q    <= free_idx_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_index_q  <= resp_index_d;
            count_q       <= count_d;
        end
    end

    for (genvar n = 0; n < NR_KEY; n++) begin : g_slot
        ysyx_040978_lut_slot #(
            .KEY_LEN  (KEY_LEN),
            .DATA_LEN (DATA_LEN)
        ) u_slot (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .load_i  (load_vec[n]),
            .clear_i (clear_vec[n]),
            .key_i   (key_q),
            .data_i  (data_q),
            .valid_o (slot_valid[n]),
            .key_o   (slot_key[n]),
            .data_o  (slot_data[n])
        );
        assign lut_o[n*PAIR +: PAIR] = {slot_key[n], slot_data[n]};
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_status_o = resp_status_q;
    assign resp_index_o  = resp_index_q;
    assign entry_valid_o = slot_valid;
    assign count_o       = count_q;
    assign full_o        = (count_q == CNT_W'(NR_KEY));
    assign empty_o       = (count_q == '0);

endmodule

// File: tb/tb_ysyx_040978_lut_writer.sv
// Randomized bench for the lookup-table writer against an array-based table model.
module tb_ysyx_040978_lut_writer;

    localparam int NK = 4;
    localparam int KL = 4;
    localparam int DL = 8;
    localparam int PW = KL + DL;

    localparam logic [1:0] W = 2'b00, D = 2'b01, C = 2'b10, R = 2'b11;
    localparam logic [1:0] S_OK = 2'b00, S_UPD = 2'b01, S_MISS = 2'b10, S_FULL = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [KL-1:0] req_key = '0;
    logic [DL-1:0] req_data = '0;
    logic          resp_valid;
    logic [1:0]    resp_status;
    logic [1:0]    resp_index;
    logic [NK*PW-1:0] lut;
    logic [NK-1:0] entry_valid;
    logic [2:0]    count;
    logic          full;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    bit            m_valid [NK];
    logic [KL-1:0] m_key   [NK];
    logic [DL-1:0] m_data  [NK];

    always #5 clock = ~clock;

    ysyx_040978_lut_writer #(
        .NR_KEY   (NK),
        .KEY_LEN  (KL),
        .DATA_LEN (DL)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_key_i     (req_key),
        .req_data_i    (req_data),
        .resp_valid_o  (resp_valid),
        .resp_status_o (resp_status),
        .resp_index_o  (resp_index),
        .lut_o         (lut),
        .entry_valid_o (entry_valid),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NK; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_data[i]  = '0;
        end
    endtask

    function automatic logic [NK*PW-1:0] model_lut();
        logic [NK*PW-1:0] r = '0;
        for (int i = 0; i < NK; i++) if (m_valid[i]) r[i*PW +: PW] = {m_key[i], m_data[i]};
        return r;
    endfunction

    function automatic logic [NK-1:0] model_ev();
        logic [NK-1:0] r = '0;
        for (int i = 0; i < NK; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NK; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // Apply a command to the model table; returns expected status and index.
    task automatic model_cmd(input logic [1:0] op, input logic [KL-1:0] k, input logic [DL-1:0] d,
                             output logic [1:0] st, output logic [1:0] idx);
        int hit = -1;
        int free = -1;
        for (int i = 0; i < NK; i++) begin
            if (hit < 0 && m_valid[i] && m_key[i] == k) hit = i;
            if (free < 0 && !m_valid[i]) free = i;
        end
        idx = 2'd0;
        case (op)
            W: begin
                if (hit >= 0) begin
                    m_data[hit] = d; st = S_UPD; idx = 2'(hit);
                end else if (free >= 0) begin
                    m_valid[free] = 1'b1; m_key[free] = k; m_data[free] = d;
                    st = S_OK; idx = 2'(free);
                end else begin
                    st = S_FULL;
                end
            end
            D: begin
                if (hit >= 0) begin
                    m_valid[hit] = 1'b0; m_key[hit] = '0; m_data[hit] = '0;
                    st = S_OK; idx = 2'(hit);
                end else begin
                    st = S_MISS;
                end
            end
            C: begin
                model_clear();
                st = S_OK;
            end
            default: st = S_MISS;
        endcase
    endtask

    // Issue one command from a negedge with the DUT idle; returns at the response negedge.
    task automatic do_cmd(input logic [1:0] op, input logic [KL-1:0] k, input logic [DL-1:0] d,
                          input string name);
        logic [1:0] est, eidx;
        int n = 0;
        bit seen = 1'b0;
        check_eq($sformatf("%s/ready", name), 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_key = k; req_data = d;
        model_cmd(op, k, d, est, eidx);
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                // Noise while busy must be ignored.
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 2'($urandom_range(0, 3));
                req_key   = KL'($urandom_range(0, 15));
                req_data  = DL'($urandom_range(0, 255));
            end
        end
        req_valid = 1'b0;
        check_eq($sformatf("%s/latency", name), 64'(n - 1), (op == W || op == D) ? 64'd5 : 64'd1);
        check_eq($sformatf("%s/status", name), 64'(resp_status), 64'(est));
        check_eq($sformatf("%s/index", name), 64'(resp_index), 64'(eidx));
        check_eq($sformatf("%s/lut", name), 64'(lut), 64'(model_lut()));
        check_eq($sformatf("%s/valid", name), 64'(entry_valid), 64'(model_ev()));
        check_eq($sformatf("%s/count", name), 64'(count), 64'(model_cnt()));
        check_eq($sformatf("%s/full", name), 64'(full), 64'(model_cnt() == NK));
        check_eq($sformatf("%s/empty", name), 64'(empty), 64'(model_cnt() == 0));
    endtask

    initial begin
        bit seen;
        int r;
        model_clear();
        repeat (2) @(negedge clock);
        check_eq("rst/ready", 64'(req_ready), 64'd1);
        check_eq("rst/resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst/status", 64'(resp_status), 64'd0);
        check_eq("rst/index", 64'(resp_index), 64'd0);
        check_eq("rst/lut", 64'(lut), 64'd0);
        check_eq("rst/valid", 64'(entry_valid), 64'd0);
        check_eq("rst/count", 64'(count), 64'd0);
        check_eq("rst/full", 64'(full), 64'd0);
        check_eq("rst/empty", 64'(empty), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        do_cmd(W, 4'd3, 8'hA5, "w3");
        check_eq("w3/slot0", 64'(lut[11:0]), 64'h3A5);
        do_cmd(W, 4'd3, 8'h5A, "upd3");
        check_eq("upd3/slot0", 64'(lut[11:0]), 64'h35A);
        do_cmd(W, 4'd1, 8'h11, "w1");
        do_cmd(W, 4'd2, 8'h22, "w2");
        do_cmd(W, 4'd4, 8'h44, "w4");
        do_cmd(W, 4'd7, 8'h77, "w7_full");
        do_cmd(D, 4'd2, 8'h00, "d2");
        check_eq("d2/slot2", 64'(lut[35:24]), 64'h0);
        do_cmd(W, 4'd7, 8'h77, "w7_ok");
        do_cmd(D, 4'd1, 8'h00, "d1");
        do_cmd(D, 4'd9, 8'h00, "d9_miss");
        do_cmd(C, 4'd0, 8'h00, "clear");
        do_cmd(R, 4'd3, 8'h33, "rsvd");
        do_cmd(W, 4'd0, 8'h00, "w0_zero");

        // Reset during the second search cycle drops the command.
        do_cmd(W, 4'd6, 8'h66, "w6");
        req_valid = 1'b1; req_op = W; req_key = 4'd5; req_data = 8'h55;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_eq("async/lut", 64'(lut), 64'd0);
        check_eq("async/valid", 64'(entry_valid), 64'd0);
        check_eq("async/ready", 64'(req_ready), 64'd1);
        check_eq("async/empty", 64'(empty), 64'd1);
        check_eq("async/count", 64'(count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        check_eq("async/no_resp", 64'(seen), 64'd0);
        do_cmd(W, 4'd5, 8'h5C, "w5_after_rst");
        do_cmd(W, 4'd8, 8'h8D, "b2b");

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            do_cmd((r < 50) ? W : (r < 85) ? D : (r < 93) ? C : R,
                   KL'($urandom_range(0, 7)), DL'($urandom_range(0, 255)),
                   $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
